// File: rtl/processador_pkg.sv
// Shared definitions for the RV64I-subset multicycle control unit:
// opcode constants, FSM state enum, instruction classes, and the
// OP_MEM_I / ULAop select codes.
package processador_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } uc_state_t;

  typedef enum logic [3:0] {
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BR,
    CL_JAL,
    CL_JALR,
    CL_AUIPC,
    CL_ILLEGAL
  } instr_class_t;

  // OP_MEM_I: operand B / write-back source select
  localparam logic [1:0] OPM_R    = 2'b00;  // B=reg, RF<-ULA
  localparam logic [1:0] OPM_LOAD = 2'b01;  // B=offset, RF<-Data
  localparam logic [1:0] OPM_IMM  = 2'b10;  // B=offset, RF<-ULA
  localparam logic [1:0] OPM_LINK = 2'b11;  // RF<-PC path

  // ULAop: operation class
  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

endpackage

// File: rtl/processador_uc_if.sv
// Control-unit <-> datapath bundle.
// master: the control unit (drives enables/selects, reads opcode/mem_ready).
// slave : the datapath/memory side.
// state_dbg exposes the FSM state for checkers.
// Handshake: mem_ready is a level qualifier sampled on the rising clk edge
// while the control unit sits in MEM; the strobe (mem_re/mem_we) stays high
// until the cycle in which mem_ready=1 is sampled (wait build only).
interface processador_uc_if #(
  parameter int CNT_W = 32
);
  import processador_pkg::*;

  logic [6:0]       opcode;
  logic             mem_ready;
  logic             IR_load;
  logic             PC_load;
  logic             RF_load;
  logic             JAL;
  logic             JALR;
  logic [1:0]       OP_MEM_I;
  logic [1:0]       ULAop;
  logic             mem_re;
  logic             mem_we;
  logic             illegal;
  logic [CNT_W-1:0] instret;
  uc_state_t        state_dbg;

  modport master (
    input  opcode, mem_ready,
    output IR_load, PC_load, RF_load, JAL, JALR, OP_MEM_I, ULAop,
           mem_re, mem_we, illegal, instret, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  IR_load, PC_load, RF_load, JAL, JALR, OP_MEM_I, ULAop,
           mem_re, mem_we, illegal, instret, state_dbg
  );
endinterface

// File: rtl/uc_decoder.sv
// Combinational opcode -> instruction class decoder.
// Ports: i_op (7-bit opcode), o_class (instruction class, CL_ILLEGAL for
// anything outside the supported subset).
module uc_decoder
  import processador_pkg::*;
(
  input  logic [6:0]   i_op,
  output instr_class_t o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_op)
      OPC_OP:     o_class = CL_R;
      OPC_OP_IMM: o_class = CL_I;
      OPC_LOAD:   o_class = CL_LOAD;
      OPC_STORE:  o_class = CL_STORE;
      OPC_BRANCH: o_class = CL_BR;
      OPC_JAL:    o_class = CL_JAL;
      OPC_JALR:   o_class = CL_JALR;
      OPC_AUIPC:  o_class = CL_AUIPC;
      default:    o_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/processador_uc.sv
// Multicycle control unit for the RV64I-subset datapath.
// Moore FSM FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus a sticky
// TRAP state for unsupported opcodes. Counts retired instructions.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - processador_uc_if.master (opcode, mem_ready in; enables,
//           selects, strobes, illegal, instret, state_dbg out)
// Build option: define UC_MEM_WAIT_EN to stretch MEM until mem_ready=1.
module processador_uc
  import processador_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  processador_uc_if.master  bus
);

  uc_state_t        r_state;
  uc_state_t        w_next;
  logic [6:0]       r_op_q;
  logic [CNT_W-1:0] r_instret;
  // Low while reset is held and until the first edge after release, so the
  // first FETCH cycle starts on that edge and all enables read 0 in reset.
  logic             r_run;

  instr_class_t w_class;       // class of the latched opcode (drives outputs)
  instr_class_t w_live_class;  // class of the incoming opcode (DECODE exit)

  logic       w_ir_load, w_pc_load, w_rf_load, w_jal, w_jalr;
  logic       w_mem_re, w_mem_we, w_illegal;
  logic [1:0] w_op_mem_i, w_ula_op;

  uc_decoder u_dec_q    (.i_op(r_op_q),     .o_class(w_class));
  uc_decoder u_dec_live (.i_op(bus.opcode), .o_class(w_live_class));

`ifndef UC_MEM_WAIT_EN
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = bus.mem_ready;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op_q    <= '0;
      r_instret <= '0;
      r_run     <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) r_state <= w_next;
      if (r_run && r_state == S_DECODE) r_op_q <= bus.opcode;
      // PC_load marks retirement; it only occurs for legal instructions.
      if (w_pc_load) r_instret <= r_instret + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_live_class == CL_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (w_class)
          CL_R, CL_I:                        w_next = S_WB;
          CL_LOAD, CL_STORE:                 w_next = S_MEM;
          CL_BR, CL_JAL, CL_JALR, CL_AUIPC:  w_next = S_FETCH;
          default:                           w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
`ifdef UC_MEM_WAIT_EN
        if (bus.mem_ready) w_next = (w_class == CL_LOAD) ? S_WB : S_FETCH;
`else
        w_next = (w_class == CL_LOAD) ? S_WB : S_FETCH;
`endif
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ir_load  = 1'b0;
    w_pc_load  = 1'b0;
    w_rf_load  = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_op_mem_i = OPM_R;
    w_ula_op   = ULA_ADD;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_illegal  = 1'b0;
    if (r_run) begin
      case (r_state)
        S_FETCH: w_ir_load = 1'b1;
        S_EXEC: begin
          case (w_class)
            CL_R: begin
              w_op_mem_i = OPM_R;
              w_ula_op   = ULA_FUNCT;
            end
            CL_I: begin
              w_op_mem_i = OPM_IMM;
              w_ula_op   = ULA_FUNCT;
            end
            CL_LOAD: begin
              w_op_mem_i = OPM_LOAD;
              w_ula_op   = ULA_ADD;
            end
            CL_STORE: begin
              w_op_mem_i = OPM_IMM;
              w_ula_op   = ULA_ADD;
            end
            CL_BR: begin
              w_ula_op  = ULA_SUB;
              w_pc_load = 1'b1;
            end
            CL_JAL, CL_JALR, CL_AUIPC: begin
              w_jal      = (w_class == CL_JAL);
              w_jalr     = (w_class == CL_JALR);
              w_op_mem_i = OPM_LINK;
              w_rf_load  = 1'b1;
              w_pc_load  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_class == CL_LOAD) begin
            w_mem_re = 1'b1;
          end else begin
            w_mem_we = 1'b1;
`ifdef UC_MEM_WAIT_EN
            // The store retires in the cycle the memory accepts it.
            w_pc_load = bus.mem_ready;
`else
            w_pc_load = 1'b1;
`endif
          end
        end
        S_WB: begin
          w_rf_load  = 1'b1;
          w_pc_load  = 1'b1;
          w_op_mem_i = (w_class == CL_LOAD) ? OPM_LOAD :
                       (w_class == CL_I)    ? OPM_IMM  : OPM_R;
        end
        S_TRAP:  w_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.IR_load   = w_ir_load;
  assign bus.PC_load   = w_pc_load;
  assign bus.RF_load   = w_rf_load;
  assign bus.JAL       = w_jal;
  assign bus.JALR      = w_jalr;
  assign bus.OP_MEM_I  = w_op_mem_i;
  assign bus.ULAop     = w_ula_op;
  assign bus.mem_re    = w_mem_re;
  assign bus.mem_we    = w_mem_we;
  assign bus.illegal   = w_illegal;
  assign bus.instret   = r_instret;
  assign bus.state_dbg = r_state;

endmodule
